// File: rtl/timer_pkg.sv
// timer_pkg: register map, control/status bit positions and byte-lane write helper for multi_timer_mmio
package timer_pkg;
    typedef enum logic [4:0] {
        REG_CTRL      = 5'h00,
        REG_COMPARE   = 5'h04,
        REG_COUNTER   = 5'h08,
        REG_PRESCALER = 5'h0C,
        REG_STATUS    = 5'h10,
        REG_DUTY      = 5'h14
    } reg_off_e;
    localparam logic [31:0] CH_STRIDE       = 32'h20;
    localparam logic [31:0] GLB_IRQ_PENDING = 32'h100;
    localparam logic [31:0] GLB_START       = 32'h104;
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_CMP_IE      = 2;
    localparam int CTRL_OVF_IE      = 3;
    localparam int CTRL_PSC_EN      = 4;
    localparam int CTRL_ONESHOT     = 5;
    localparam int CTRL_PWM_EN      = 6;
    localparam int STATUS_CMP       = 0;
    localparam int STATUS_OVF       = 1;
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] wstrb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{wstrb[i]}};
        return (old & ~m) | (wdata & m);
    endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel (prescaler, counter, sticky flags, irq, optional PWM).
// Ports: clk, resetn (sync, active-low); *_we register write strobes with wdata/wstrb;
// start forces EN; ctrl/compare/counter/prescaler/duty/status register contents; irq, pwm.
// PWM is compiled in only when TIMER_PWM_EN is defined; otherwise DUTY and CTRL[6] stay 0.
module timer_channel
    import timer_pkg::*;
#(
    parameter int          CNT_W         = 32,
    parameter logic [31:0] DEF_PRESCALER = 32'd99_999
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ctrl_we,
    input  logic             compare_we,
    input  logic             counter_we,
    input  logic             prescaler_we,
    input  logic             status_we,
    input  logic             duty_we,
    input  logic             start,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [6:0]       ctrl,
    output logic [CNT_W-1:0] compare,
    output logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] prescaler,
    output logic [CNT_W-1:0] duty,
    output logic [1:0]       status,
    output logic             irq,
    output logic             pwm
);
`ifdef TIMER_PWM_EN
    localparam logic PWM_ON = 1'b1;
`else
    localparam logic PWM_ON = 1'b0;
`endif
    localparam logic [6:0]       CTRL_MASK = {PWM_ON, 6'h3F};
    localparam logic [CNT_W-1:0] ONES      = '1;

    logic [CNT_W-1:0] psc_cnt, counter_next;
    logic [6:0]       ctrl_next;
    logic             tick, match, ovf_set;

    always_comb begin
        tick    = ctrl[CTRL_EN] && (!ctrl[CTRL_PSC_EN] || psc_cnt == '0);
        match   = counter == compare;
        // compare match wins; with AUTO_RELOAD on an all-ones compare only CMP is raised
        ovf_set = tick && counter == ONES && !(match && ctrl[CTRL_AUTO_RELOAD]);
        // all-ones + 1 wraps to 0, which covers both the overflow and the non-reloading match on all-ones
        counter_next = counter_we ? CNT_W'(lane_merge(32'(counter), wdata, wstrb))
                     : !tick ? counter
                     : (match && ctrl[CTRL_AUTO_RELOAD]) ? '0 : counter + 1'b1;
        ctrl_next = ctrl_we ? 7'(lane_merge(32'(ctrl), wdata, wstrb)) & CTRL_MASK : ctrl;
        if (!ctrl_we && tick && match && ctrl[CTRL_ONESHOT]) ctrl_next[CTRL_EN] = 1'b0;
        if (start) ctrl_next[CTRL_EN] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl      <= '0;
            compare   <= ONES;
            counter   <= '0;
            prescaler <= CNT_W'(DEF_PRESCALER);
            duty      <= '0;
            status    <= '0;
            psc_cnt   <= '0;
            irq       <= 1'b0;
            pwm       <= 1'b0;
        end else begin
            ctrl      <= ctrl_next;
            compare   <= compare_we ? CNT_W'(lane_merge(32'(compare), wdata, wstrb)) : compare;
            counter   <= counter_next;
            prescaler <= prescaler_we ? CNT_W'(lane_merge(32'(prescaler), wdata, wstrb)) : prescaler;
            duty      <= (duty_we ? CNT_W'(lane_merge(32'(duty), wdata, wstrb)) : duty) & {CNT_W{PWM_ON}};
            // hardware set is OR-ed in after the W1C so it wins a same-cycle clear
            status    <= (status & ~(status_we ? wdata[1:0] & {2{wstrb[0]}} : 2'b00)) | {ovf_set, tick && match};
            psc_cnt   <= (!ctrl[CTRL_EN] || !ctrl[CTRL_PSC_EN]) ? '0
                       : psc_cnt == '0 ? prescaler : psc_cnt - 1'b1;
            irq       <= (status[STATUS_CMP] && ctrl[CTRL_CMP_IE]) || (status[STATUS_OVF] && ctrl[CTRL_OVF_IE]);
            pwm       <= PWM_ON && ctrl[CTRL_EN] && ctrl[CTRL_PWM_EN] && counter < duty;
        end
    end
endmodule

// File: rtl/multi_timer_mmio.sv
// multi_timer_mmio: N_CH-channel memory-mapped timer with compare/overflow irqs and optional PWM.
// Ports: clk, resetn (sync, active-low); picorv32-style bus mem_valid/mem_instr/mem_ready/
// mem_addr/mem_wdata/mem_wstrb/mem_rdata; irq per channel, timer_irq (OR of irq), pwm_out.
// Macro TIMER_PWM_EN enables the PWM outputs and DUTY registers.
module multi_timer_mmio
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8100_7000,
    parameter int          N_CH          = 4,
    parameter int          CNT_W         = 32,
    parameter logic [31:0] DEF_PRESCALER = 32'd99_999
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mem_valid,
    input  logic            mem_instr,
    output logic            mem_ready,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_wdata,
    input  logic [3:0]      mem_wstrb,
    output logic [31:0]     mem_rdata,
    output logic [N_CH-1:0] irq,
    output logic            timer_irq,
    output logic [N_CH-1:0] pwm_out
);
    logic [31:0]      off, rd_val;
    logic [2:0]       ch_sel;
    logic             pending, accept, wr, ch_hit;
    logic [N_CH-1:0]  start;
    logic [6:0]       ctrl      [N_CH];
    logic [CNT_W-1:0] compare   [N_CH];
    logic [CNT_W-1:0] counter   [N_CH];
    logic [CNT_W-1:0] prescaler [N_CH];
    logic [CNT_W-1:0] duty      [N_CH];
    logic [1:0]       status    [N_CH];

    always_comb begin
        off    = mem_addr - BASE_ADDR;
        ch_sel = off[7:5];
        ch_hit = off < 32'(N_CH) * CH_STRIDE;
        // pending blocks a second ready until mem_valid has dropped
        accept = mem_valid && !mem_instr && !pending;
        wr     = accept && mem_wstrb != 4'b0;
        start  = (wr && off == GLB_START) ? mem_wdata[N_CH-1:0] & {N_CH{mem_wstrb[0]}} : '0;
        rd_val = off == GLB_IRQ_PENDING ? 32'(irq) : 32'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_hit && ch_sel == 3'(c)) begin
                case (off[4:0])
                    REG_CTRL:      rd_val = 32'(ctrl[c]);
                    REG_COMPARE:   rd_val = 32'(compare[c]);
                    REG_COUNTER:   rd_val = 32'(counter[c]);
                    REG_PRESCALER: rd_val = 32'(prescaler[c]);
                    REG_STATUS:    rd_val = 32'(status[c]);
                    REG_DUTY:      rd_val = 32'(duty[c]);
                    default:       rd_val = 32'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending   <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'b0;
        end else begin
            pending   <= mem_valid && (pending || accept);
            mem_ready <= accept;
            mem_rdata <= accept ? rd_val : 32'b0;
        end
    end

    assign timer_irq = |irq;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic sel;
        assign sel = wr && ch_hit && ch_sel == 3'(g);
        timer_channel #(.CNT_W(CNT_W), .DEF_PRESCALER(DEF_PRESCALER)) u_ch (
            .clk          (clk),
            .resetn       (resetn),
            .ctrl_we      (sel && off[4:0] == REG_CTRL),
            .compare_we   (sel && off[4:0] == REG_COMPARE),
            .counter_we   (sel && off[4:0] == REG_COUNTER),
            .prescaler_we (sel && off[4:0] == REG_PRESCALER),
            .status_we    (sel && off[4:0] == REG_STATUS),
            .duty_we      (sel && off[4:0] == REG_DUTY),
            .start        (start[g]),
            .wdata        (mem_wdata),
            .wstrb        (mem_wstrb),
            .ctrl         (ctrl[g]),
            .compare      (compare[g]),
            .counter      (counter[g]),
            .prescaler    (prescaler[g]),
            .duty         (duty[g]),
            .status       (status[g]),
            .irq          (irq[g]),
            .pwm          (pwm_out[g])
        );
    end
endmodule
